ysyx_24110006_trap_ctrl: RTL and testbench

Multi-cycle trap sequencer between the EXU and the machine-mode CSR file. It accepts one trap/return request per handshake and resolves priority between a pending timer interrupt and synchronous exceptions. It drives the CSR file's single write port over successive cycles (mepc, mcause, mstatus) and then issues a PC redirect to the IFU. It is the only writer of mepc, mcause and mstatus while busy.

---
 rtl/ysyx_24110006_trap_ctrl_if.sv | 53 +++++
 rtl/ysyx_24110006_trap_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ysyx_24110006_trap_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24110006_trap_ctrl_if.sv
// ysyx_24110006_trap_ctrl_if
// Bundles every non-clock signal of the trap sequencer. The signals are the
// EXU request, the live CSR read values, the CSR write port, and the IFU
// redirect handshake. Signal names are written from the trap controller's
// point of view: i_* flows into the controller and o_* flows out of it.
//   slave  : the trap controller itself
//   master : the surrounding core (EXU / CSR file / IFU), or a testbench
// Parameters: CSR_AW (CSR address width), XLEN (data width).
interface ysyx_24110006_trap_ctrl_if #(
  parameter int CSR_AW = 12,
  parameter int XLEN   = 32
);
  // EXU request handshake and exception flags
  logic              i_valid;
  logic              o_ready;
  logic              i_ecall;
  logic              i_ebreak;
  logic              i_illegal;
  logic              i_mret;
  logic [XLEN-1:0]   i_pc;
  logic [XLEN-1:0]   i_npc;
  logic              i_mtip;

  // live CSR read values
  logic [XLEN-1:0]   i_mstatus;
  logic [XLEN-1:0]   i_mtvec;
  logic [XLEN-1:0]   i_mepc;

  // single CSR write port
  logic              o_csr_we;
  logic [CSR_AW-1:0] o_csr_waddr;
  logic [XLEN-1:0]   o_csr_wdata;

  // IFU redirect handshake
  logic              o_redir_valid;
  logic [XLEN-1:0]   o_redir_pc;
  logic              i_redir_ready;
  logic              o_trap_taken;

  modport slave (
    input  i_valid, i_ecall, i_ebreak, i_illegal, i_mret, i_pc, i_npc, i_mtip,
    input  i_mstatus, i_mtvec, i_mepc, i_redir_ready,
    output o_ready, o_csr_we, o_csr_waddr, o_csr_wdata,
    output o_redir_valid, o_redir_pc, o_trap_taken
  );

  modport master (
    output i_valid, i_ecall, i_ebreak, i_illegal, i_mret, i_pc, i_npc, i_mtip,
    output i_mstatus, i_mtvec, i_mepc, i_redir_ready,
    input  o_ready, o_csr_we, o_csr_waddr, o_csr_wdata,
    input  o_redir_valid, o_redir_pc, o_trap_taken
  );
endinterface

// File: rtl/ysyx_24110006_trap_ctrl.sv
// ysyx_24110006_trap_ctrl
// Multi-cycle trap sequencer that sits between the EXU and the machine-mode
// CSR file. It accepts one trap or mret request per handshake. For a trap
// entry it writes mepc, mcause and mstatus over three cycles and then
// redirects the IFU to mtvec. For mret it rewrites mstatus and then redirects
// the IFU to mepc.
// Ports:
//   i_clock - clock
//   i_reset - synchronous active-high reset
//   bus     - ysyx_24110006_trap_ctrl_if.slave carrying the request,
//             CSR read values, CSR write port and redirect handshake
module ysyx_24110006_trap_ctrl #(
  parameter int CSR_AW = 12,
  parameter int XLEN   = 32
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  ysyx_24110006_trap_ctrl_if.slave      bus
);

  localparam logic [CSR_AW-1:0] ADDR_MSTATUS = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] ADDR_MEPC    = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] ADDR_MCAUSE  = CSR_AW'(12'h342);

  localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(2);
  localparam logic [XLEN-1:0] CAUSE_EBREAK  = XLEN'(3);
  localparam logic [XLEN-1:0] CAUSE_ECALL   = XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_MTIMER  = {1'b1, (XLEN-1)'(7)};

  typedef enum logic [2:0] {
    IDLE,
    WR_MEPC,
    WR_MCAUSE,
    WR_MSTATUS,
    MRET_MST,
    REDIRECT
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic            mret_q, mret_d;

  logic            irq_enabled;
  logic [XLEN-1:0] mstatus_entry;
  logic [XLEN-1:0] mstatus_ret;
  logic [XLEN-1:0] tvec_base;
  logic [XLEN-1:0] entry_target;

  // State and latched request fields. Reset abandons any partial trap.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      epc_q   <= '0;
      cause_q <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      mret_q  <= mret_d;
    end
  end

  // mstatus images for trap entry and mret. They are built from the live
  // value so that the fields we do not own pass through unchanged.
  // On entry MIE is stacked into MPIE. On return MPIE is restored into MIE.
  // Both paths leave MPP at M-mode, because this core has no other
  // privilege mode.
  always_comb begin
    irq_enabled = bus.i_mtip & bus.i_mstatus[3];

    mstatus_entry        = bus.i_mstatus;
    mstatus_entry[7]     = bus.i_mstatus[3];
    mstatus_entry[3]     = 1'b0;
    mstatus_entry[12:11] = 2'b11;

    mstatus_ret          = bus.i_mstatus;
    mstatus_ret[3]       = bus.i_mstatus[7];
    mstatus_ret[7]       = 1'b1;
    mstatus_ret[12:11]   = 2'b11;

    // Vectored mode offsets only interrupts. Shifting the whole cause left
    // by two drops the interrupt bit, which gives 4*cause[30:0] mod 2^XLEN.
    tvec_base = {bus.i_mtvec[XLEN-1:2], 2'b00};
    if (bus.i_mtvec[1:0] == 2'b01 && cause_q[XLEN-1])
      entry_target = tvec_base + (cause_q << 2);
    else
      entry_target = tvec_base;
  end

  // Next-state and output decode. Flags are looked at only on the accepting
  // cycle, so later changes on i_mtip or on the exception lines are ignored
  // while busy. A request with nothing to do is consumed without leaving
  // IDLE.
  always_comb begin
    state_d           = state_q;
    epc_d             = epc_q;
    cause_d           = cause_q;
    mret_d            = mret_q;
    bus.o_ready       = 1'b0;
    bus.o_csr_we      = 1'b0;
    bus.o_csr_waddr   = '0;
    bus.o_csr_wdata   = '0;
    bus.o_redir_valid = 1'b0;
    bus.o_redir_pc    = '0;
    bus.o_trap_taken  = 1'b0;

    case (state_q)
      IDLE: begin
        bus.o_ready = 1'b1;
        if (bus.i_valid) begin
          mret_d = 1'b0;
          if (bus.i_illegal) begin
            cause_d = CAUSE_ILLEGAL;
            epc_d   = bus.i_pc;
            state_d = WR_MEPC;
          end else if (bus.i_ebreak) begin
            cause_d = CAUSE_EBREAK;
            epc_d   = bus.i_pc;
            state_d = WR_MEPC;
          end else if (bus.i_ecall) begin
            cause_d = CAUSE_ECALL;
            epc_d   = bus.i_pc;
            state_d = WR_MEPC;
          end else if (bus.i_mret) begin
            mret_d  = 1'b1;
            state_d = MRET_MST;
          end else if (irq_enabled) begin
            // The requesting instruction retires, so the return point is
            // the next sequential PC.
            cause_d = CAUSE_MTIMER;
            epc_d   = bus.i_npc;
            state_d = WR_MEPC;
          end
        end
      end
      WR_MEPC: begin
        bus.o_csr_we    = 1'b1;
        bus.o_csr_waddr = ADDR_MEPC;
        bus.o_csr_wdata = epc_q;
        state_d         = WR_MCAUSE;
      end
      WR_MCAUSE: begin
        bus.o_csr_we    = 1'b1;
        bus.o_csr_waddr = ADDR_MCAUSE;
        bus.o_csr_wdata = cause_q;
        state_d         = WR_MSTATUS;
      end
      WR_MSTATUS: begin
        bus.o_csr_we    = 1'b1;
        bus.o_csr_waddr = ADDR_MSTATUS;
        bus.o_csr_wdata = mstatus_entry;
        state_d         = REDIRECT;
      end
      MRET_MST: begin
        bus.o_csr_we    = 1'b1;
        bus.o_csr_waddr = ADDR_MSTATUS;
        bus.o_csr_wdata = mstatus_ret;
        state_d         = REDIRECT;
      end
      REDIRECT: begin
        // The target comes from live CSRs. They are stable here because
        // this block is the only writer and it writes nothing in this state.
        bus.o_redir_valid = 1'b1;
        bus.o_redir_pc    = mret_q ? bus.i_mepc : entry_target;
        if (bus.i_redir_ready) begin
          bus.o_trap_taken = ~mret_q;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24110006_trap_ctrl.sv
// tb_ysyx_24110006_trap_ctrl
// Directed testbench for the trap sequencer. A small CSR-file model captures
// the DUT's writes and feeds mstatus and mepc back to it.
module tb_ysyx_24110006_trap_ctrl;

  logic clock;
  logic reset;

  ysyx_24110006_trap_ctrl_if #(.CSR_AW(12), .XLEN(32)) bus();

  ysyx_24110006_trap_ctrl #(.CSR_AW(12), .XLEN(32)) dut (
    .i_clock (clock),
    .i_reset (reset),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // CSR-file model: a preload port for test setup, plus the DUT write port.
  logic        loadEn;
  logic [31:0] loadMepc, loadMstatus;
  logic [31:0] csrMepc, csrMcause, csrMstatus;
  int          writeCount;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Capture the DUT's CSR writes, or take a preload from the stimulus.
  always @(posedge clock) begin
    if (loadEn) begin
      csrMepc    <= loadMepc;
      csrMstatus <= loadMstatus;
      csrMcause  <= 32'h0;
    end else if (bus.o_csr_we) begin
      writeCount <= writeCount + 1;
      case (bus.o_csr_waddr)
        12'h341: csrMepc    <= bus.o_csr_wdata;
        12'h342: csrMcause  <= bus.o_csr_wdata;
        12'h300: csrMstatus <= bus.o_csr_wdata;
        default: ;
      endcase
    end
  end

  assign bus.i_mstatus = csrMstatus;
  assign bus.i_mepc    = csrMepc;

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic valid, input logic ecall,
                               input logic ebreak, input logic illegal,
                               input logic mret, input logic mtip,
                               input logic [31:0] pc, input logic [31:0] npc);
    bus.i_valid   = valid;
    bus.i_ecall   = ecall;
    bus.i_ebreak  = ebreak;
    bus.i_illegal = illegal;
    bus.i_mret    = mret;
    bus.i_mtip    = mtip;
    bus.i_pc      = pc;
    bus.i_npc     = npc;
    #1;
  endtask

  task automatic idleStimulus;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic preload(input logic [31:0] mepc, input logic [31:0] mstatus);
    loadEn      = 1'b1;
    loadMepc    = mepc;
    loadMstatus = mstatus;
    tick();
    loadEn      = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkWrite(input string tag, input logic [11:0] addr,
                            input logic [31:0] data);
    checkOutput({tag, "_we"}, {31'b0, bus.o_csr_we}, 32'h1);
    checkOutput({tag, "_waddr"}, {20'b0, bus.o_csr_waddr}, {20'b0, addr});
    checkOutput({tag, "_wdata"}, bus.o_csr_wdata, data);
  endtask

  int savedWrites;

  initial begin
    reset             = 1'b1;
    loadEn            = 1'b0;
    loadMepc          = 32'h0;
    loadMstatus       = 32'h0;
    writeCount        = 0;
    bus.i_mtvec       = 32'h8000_0100;
    bus.i_redir_ready = 1'b1;
    idleStimulus();
    preload(32'h0, 32'h8);
    tick();

    // Reset state
    checkOutput("rst_ready", {31'b0, bus.o_ready}, 32'h1);
    checkOutput("rst_we", {31'b0, bus.o_csr_we}, 32'h0);
    checkOutput("rst_waddr", {20'b0, bus.o_csr_waddr}, 32'h0);
    checkOutput("rst_wdata", bus.o_csr_wdata, 32'h0);
    checkOutput("rst_rvalid", {31'b0, bus.o_redir_valid}, 32'h0);
    checkOutput("rst_rpc", bus.o_redir_pc, 32'h0);
    checkOutput("rst_taken", {31'b0, bus.o_trap_taken}, 32'h0);
    reset = 1'b0;
    tick();

    // ecall entry with full timing
    $display("[TB] ecall entry");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0010, 32'h8000_0014);
    checkOutput("ecall_ready", {31'b0, bus.o_ready}, 32'h1);
    tick(); idleStimulus();
    checkOutput("ecall_t1_ready", {31'b0, bus.o_ready}, 32'h0);
    checkWrite("ecall_mepc", 12'h341, 32'h8000_0010);
    tick();
    checkWrite("ecall_mcause", 12'h342, 32'd11);
    tick();
    checkWrite("ecall_mstatus", 12'h300, 32'h1880);
    tick();
    checkOutput("ecall_t4_we", {31'b0, bus.o_csr_we}, 32'h0);
    checkOutput("ecall_rvalid", {31'b0, bus.o_redir_valid}, 32'h1);
    checkOutput("ecall_rpc", bus.o_redir_pc, 32'h8000_0100);
    checkOutput("ecall_taken", {31'b0, bus.o_trap_taken}, 32'h1);
    checkOutput("ecall_csr_mepc", csrMepc, 32'h8000_0010);
    checkOutput("ecall_csr_mcause", csrMcause, 32'd11);
    checkOutput("ecall_csr_mstatus", csrMstatus, 32'h1880);
    tick();
    checkOutput("ecall_t5_ready", {31'b0, bus.o_ready}, 32'h1);
    checkOutput("ecall_t5_taken", {31'b0, bus.o_trap_taken}, 32'h0);
    checkOutput("ecall_t5_rvalid", {31'b0, bus.o_redir_valid}, 32'h0);

    // illegal beats ecall
    $display("[TB] priority");
    preload(32'h0, 32'h8);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0030, 32'h8000_0034);
    tick(); idleStimulus();
    tick(); tick(); tick();
    checkOutput("prio_ill_mcause", csrMcause, 32'd2);
    checkOutput("prio_ill_mepc", csrMepc, 32'h8000_0030);
    tick();

    // ecall beats an enabled timer interrupt
    preload(32'h0, 32'h8);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0040, 32'h8000_0044);
    tick(); idleStimulus();
    tick(); tick(); tick();
    checkOutput("prio_ecall_mcause", csrMcause, 32'd11);
    checkOutput("prio_ecall_mepc", csrMepc, 32'h8000_0040);
    checkOutput("prio_ecall_rpc", bus.o_redir_pc, 32'h8000_0100);
    tick();

    // timer interrupt with vectored mtvec
    $display("[TB] timer interrupt");
    bus.i_mtvec = 32'h8000_0101;
    preload(32'h0, 32'h8);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0020, 32'h8000_0024);
    tick(); idleStimulus();
    checkWrite("irq_mepc", 12'h341, 32'h8000_0024);
    tick();
    checkWrite("irq_mcause", 12'h342, 32'h8000_0007);
    tick();
    checkWrite("irq_mstatus", 12'h300, 32'h1880);
    tick();
    checkOutput("irq_rpc", bus.o_redir_pc, 32'h8000_011C);
    checkOutput("irq_taken", {31'b0, bus.o_trap_taken}, 32'h1);
    tick();

    // timer pending but MIE clear: nothing happens
    preload(32'h0, 32'h0);
    savedWrites = writeCount;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0020, 32'h8000_0024);
    tick(); idleStimulus();
    checkOutput("irq_off_ready", {31'b0, bus.o_ready}, 32'h1);
    checkOutput("irq_off_we", {31'b0, bus.o_csr_we}, 32'h0);
    tick();
    checkOutput("irq_off_rvalid", {31'b0, bus.o_redir_valid}, 32'h0);
    checkOutput("irq_off_writes", writeCount, savedWrites);
    bus.i_mtvec = 32'h8000_0100;

    // mret
    $display("[TB] mret");
    preload(32'h8000_0014, 32'h1880);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0050, 32'h8000_0054);
    tick(); idleStimulus();
    checkWrite("mret_mstatus", 12'h300, 32'h1888);
    tick();
    checkOutput("mret_rvalid", {31'b0, bus.o_redir_valid}, 32'h1);
    checkOutput("mret_rpc", bus.o_redir_pc, 32'h8000_0014);
    checkOutput("mret_taken", {31'b0, bus.o_trap_taken}, 32'h0);
    checkOutput("mret_csr_mstatus", csrMstatus, 32'h1888);
    tick();
    checkOutput("mret_ready", {31'b0, bus.o_ready}, 32'h1);

    // redirect backpressure
    $display("[TB] redirect stall");
    preload(32'h0, 32'h8);
    bus.i_redir_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0050, 32'h8000_0054);
    tick(); idleStimulus();
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_rvalid", {31'b0, bus.o_redir_valid}, 32'h1);
      checkOutput("stall_rpc", bus.o_redir_pc, 32'h8000_0100);
      checkOutput("stall_ready", {31'b0, bus.o_ready}, 32'h0);
      checkOutput("stall_taken", {31'b0, bus.o_trap_taken}, 32'h0);
      tick();
    end
    bus.i_redir_ready = 1'b1;
    #1;
    checkOutput("stall_rel_taken", {31'b0, bus.o_trap_taken}, 32'h1);
    checkOutput("stall_rel_rpc", bus.o_redir_pc, 32'h8000_0100);
    tick();
    checkOutput("stall_rel_ready", {31'b0, bus.o_ready}, 32'h1);

    // reset in the middle of an entry sequence
    $display("[TB] mid-sequence reset");
    preload(32'h0, 32'h8);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0060, 32'h8000_0064);
    tick(); idleStimulus();
    tick();
    checkOutput("midrst_in_mcause", {20'b0, bus.o_csr_waddr}, 32'h342);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    savedWrites = writeCount;
    checkOutput("midrst_ready", {31'b0, bus.o_ready}, 32'h1);
    checkOutput("midrst_we", {31'b0, bus.o_csr_we}, 32'h0);
    checkOutput("midrst_rvalid", {31'b0, bus.o_redir_valid}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("midrst_after_we", {31'b0, bus.o_csr_we}, 32'h0);
      checkOutput("midrst_after_rvalid", {31'b0, bus.o_redir_valid}, 32'h0);
    end
    checkOutput("midrst_mstatus", csrMstatus, 32'h8);
    checkOutput("midrst_writes", writeCount, savedWrites);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
